io_input_cond: RTL and testbench

Input conditioning stage that sits directly upstream of the LSU input-peripheral region. It conditions the raw board switches and push-buttons before the LSU returns them on loads from 0x7800 (switches) and 0x7810 (buttons).
- Switches: 2-FF synchronised only.
- Buttons: synchronised, then debounced per bit.
- Also produces one-cycle press/release pulses for future interrupt/event logic.

---
 rtl/io_input_cond.sv | 82 ++++++++
 tb/tb_io_input_cond.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/io_input_cond.sv
// Input conditioning for the LSU peripheral region: 2-FF synchronised switches,
// synchronised and per-bit debounced buttons, plus one-cycle press/release pulses.
module io_input_cond #(
  parameter int SW_WIDTH       = 32,
  parameter int BTN_WIDTH      = 4,
  parameter int DB_CYCLES      = 500000,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [SW_WIDTH-1:0]  i_sw_raw,
  input  logic [BTN_WIDTH-1:0] i_btn_raw,
  output logic [SW_WIDTH-1:0]  o_io_sw,
  output logic [BTN_WIDTH-1:0] o_io_btn,
  output logic [BTN_WIDTH-1:0] o_btn_press,
  output logic [BTN_WIDTH-1:0] o_btn_release
);

  // A one-cycle debounce still needs a 1-bit counter to keep the array legal.
  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [BTN_WIDTH-1:0] IDLE    = {BTN_WIDTH{BTN_ACTIVE_LOW != 0}};

  logic [SW_WIDTH-1:0]  sw_p0, sw_p1;
  logic [BTN_WIDTH-1:0] btn_p0, btn_p1;
  logic [BTN_WIDTH-1:0] db, db_prev;
  logic [CNT_W-1:0]     cnt [BTN_WIDTH];
  logic [BTN_WIDTH-1:0] press, release_q;

  // Stage p0/p1: two-flop synchronisers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sw_p0  <= '0;
      sw_p1  <= '0;
      btn_p0 <= IDLE;
      btn_p1 <= IDLE;
    end else begin
      sw_p0  <= i_sw_raw;
      sw_p1  <= sw_p0;
      btn_p0 <= i_btn_raw;
      btn_p1 <= btn_p0;
    end
  end

  // Debounce stage: a change is accepted only after DB_CYCLES consecutive mismatches
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      db <= IDLE;
      for (int i = 0; i < BTN_WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < BTN_WIDTH; i++) begin
        if (btn_p1[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= btn_p1[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge stage: compare debounced value against its previous cycle
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      db_prev   <= IDLE;
      press     <= '0;
      release_q <= '0;
    end else begin
      db_prev   <= db;
      press     <= ~(db_prev ^ IDLE) &  (db ^ IDLE);
      release_q <=  (db_prev ^ IDLE) & ~(db ^ IDLE);
    end
  end

  assign o_io_sw       = sw_p1;
  assign o_io_btn      = db;
  assign o_btn_press   = press;
  assign o_btn_release = release_q;

endmodule

// File: tb/tb_io_input_cond.sv
// Scoreboard bench for io_input_cond (DB_CYCLES=4, active-low buttons): stimulus
// queues expected output events with their cycle, a monitor pops them on change.
module tb_io_input_cond;
  localparam int SW_WIDTH  = 32;
  localparam int BTN_WIDTH = 4;
  localparam int DB        = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [SW_WIDTH-1:0]  sw_raw;
  logic [BTN_WIDTH-1:0] btn_raw;
  logic [SW_WIDTH-1:0]  io_sw;
  logic [BTN_WIDTH-1:0] io_btn, btn_press, btn_release;

  io_input_cond #(
    .SW_WIDTH(SW_WIDTH), .BTN_WIDTH(BTN_WIDTH), .DB_CYCLES(DB), .BTN_ACTIVE_LOW(1)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .i_sw_raw(sw_raw), .i_btn_raw(btn_raw),
    .o_io_sw(io_sw), .o_io_btn(io_btn), .o_btn_press(btn_press), .o_btn_release(btn_release)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } ev_t;

  ev_t q_sw[$];
  ev_t q_btn[$];
  ev_t q_pulse[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raw change driven now lands before edge cyc+1.
  task automatic push_btn(input logic [3:0] btn, input logic [3:0] pr, input logic [3:0] rl);
    ev_t e;
    e.val = {28'h0, btn};       e.cyc = cyc + 2 + DB; q_btn.push_back(e);
    e.val = {24'h0, pr, rl};    e.cyc = cyc + 3 + DB; q_pulse.push_back(e);
  endtask

  task automatic push_sw(input logic [31:0] v);
    ev_t e;
    e.val = v; e.cyc = cyc + 2; q_sw.push_back(e);
  endtask

  // Monitor: every output change must match the head of its queue, value and cycle.
  logic [SW_WIDTH-1:0]  prev_sw;
  logic [BTN_WIDTH-1:0] prev_btn;
  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      prev_sw  = io_sw;
      prev_btn = io_btn;
    end else begin
      if (io_sw !== prev_sw) begin
        if (q_sw.size() == 0) begin
          errors++;
          $display("FAIL sw_unexpected: got %0h expected %0h (cycle %0d)", io_sw, prev_sw, cyc);
        end else begin
          e = q_sw.pop_front();
          check("sw_val", io_sw, e.val);
          check("sw_cyc", cyc, e.cyc);
        end
        prev_sw = io_sw;
      end
      if (io_btn !== prev_btn) begin
        if (q_btn.size() == 0) begin
          errors++;
          $display("FAIL btn_unexpected: got %0h expected %0h (cycle %0d)", io_btn, prev_btn, cyc);
        end else begin
          e = q_btn.pop_front();
          check("btn_val", io_btn, e.val);
          check("btn_cyc", cyc, e.cyc);
        end
        prev_btn = io_btn;
      end
      if ((btn_press | btn_release) != 0) begin
        if (q_pulse.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected: got press %0h release %0h expected none (cycle %0d)",
                   btn_press, btn_release, cyc);
        end else begin
          e = q_pulse.pop_front();
          check("pulse_val", {btn_press, btn_release}, e.val);
          check("pulse_cyc", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    // Reset state
    rst_n   = 1'b0;
    btn_raw = 4'hF;
    sw_raw  = '0;
    wait_cyc(3);
    check("rst_btn", io_btn, 4'hF);
    check("rst_sw", io_sw, 0);
    check("rst_press", btn_press, 0);
    check("rst_release", btn_release, 0);
    rst_n = 1'b1;
    wait_cyc(3);
    check("post_rst_btn", io_btn, 4'hF);
    check("post_rst_sw", io_sw, 0);
    check("post_rst_pulses", {btn_press, btn_release}, 0);

    // Switch path: two-cycle latency
    sw_raw = 32'hDEADBEEF;
    push_sw(32'hDEADBEEF);
    wait_cyc(4);

    // Single button press and release
    btn_raw = 4'hE; push_btn(4'hE, 4'h1, 4'h0);
    wait_cyc(10);
    btn_raw = 4'hF; push_btn(4'hF, 4'h0, 4'h1);
    wait_cyc(10);

    // Bounce shorter than the debounce window is discarded
    btn_raw = 4'hD; wait_cyc(2);
    btn_raw = 4'hF; wait_cyc(2);
    btn_raw = 4'hD; wait_cyc(2);
    btn_raw = 4'hF; wait_cyc(10);
    check("bounce_btn", io_btn, 4'hF);
    // A clean press afterwards must take the full window, proving the counter cleared
    btn_raw = 4'hD; push_btn(4'hD, 4'h2, 4'h0);
    wait_cyc(10);
    btn_raw = 4'hF; push_btn(4'hF, 4'h0, 4'h2);
    wait_cyc(10);

    // Two buttons in parallel
    btn_raw = 4'h3; push_btn(4'h3, 4'hC, 4'h0);
    wait_cyc(10);
    btn_raw = 4'hF; push_btn(4'hF, 4'h0, 4'hC);
    wait_cyc(10);

    // Reset mid-count with the button held through reset release
    btn_raw = 4'hE;
    wait_cyc(4);
    rst_n = 1'b0;
    wait_cyc(1);
    check("midrst_btn", io_btn, 4'hF);
    check("midrst_sw", io_sw, 0);
    check("midrst_pulses", {btn_press, btn_release}, 0);
    wait_cyc(2);
    rst_n = 1'b1;
    push_sw(32'hDEADBEEF);
    push_btn(4'hE, 4'h1, 4'h0);
    wait_cyc(10);
    btn_raw = 4'hF; push_btn(4'hF, 4'h0, 4'h1);
    wait_cyc(12);

    check("pending_sw", q_sw.size(), 0);
    check("pending_btn", q_btn.size(), 0);
    check("pending_pulse", q_pulse.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
